// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU operation codes, FSM state encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // These codes are shared with the upstream ALU-control decoder.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational single-cycle ALU ops plus undefined-code detect.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_alucon,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);

    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_alucon)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_AND: o_result = i_a & i_b;
            // A zero-distance shift completes here and simply passes op_a.
            ALU_SLL,
            ALU_SRL: o_result = i_a;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU with valid/ready handshakes and a bit-serial
//            shifter; single-cycle ops retire back-to-back at 1 op/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucon,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_t               r_state;
    logic [XLEN-1:0]      r_work;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_dir_right;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic                 r_illegal;
    logic                 r_out_valid;

    state_t               w_state_nxt;
    logic [XLEN-1:0]      w_work_nxt;
    logic [SHAMT_W-1:0]   w_cnt_nxt;
    logic                 w_dir_right_nxt;
    logic [XLEN-1:0]      w_result_nxt;
    logic                 w_zero_nxt;
    logic                 w_illegal_nxt;
    logic                 w_out_valid_nxt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [XLEN-1:0]      w_core_result;
    logic                 w_core_illegal;
    logic [XLEN-1:0]      w_shifted;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_alucon  (alucon),
        .i_a       (op_a),
        .i_b       (op_b),
        .o_result  (w_core_result),
        .o_illegal (w_core_illegal)
    );

    // Ready depends only on registered state, never on in_valid.
    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_shamt    = op_b[SHAMT_W-1:0];
    assign w_shifted  = r_dir_right ? (r_work >> 1) : (r_work << 1);

    always_comb begin
        w_state_nxt     = r_state;
        w_work_nxt      = r_work;
        w_cnt_nxt       = r_cnt;
        w_dir_right_nxt = r_dir_right;
        w_result_nxt    = r_result;
        w_zero_nxt      = r_zero;
        w_illegal_nxt   = r_illegal;
        w_out_valid_nxt = r_out_valid;

        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_shift_op(alucon) && (w_shamt != '0)) begin
                        w_work_nxt      = op_a;
                        w_cnt_nxt       = w_shamt;
                        w_dir_right_nxt = (alucon == ALU_SRL);
                        w_state_nxt     = ST_SHIFT;
                    end else begin
                        w_result_nxt    = w_core_result;
                        w_zero_nxt      = (w_core_result == '0);
                        w_illegal_nxt   = w_core_illegal;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt - SHAMT_W'(1);
                if (r_cnt == SHAMT_W'(1)) begin
                    w_result_nxt    = w_shifted;
                    w_zero_nxt      = (w_shifted == '0);
                    w_illegal_nxt   = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_dir_right <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir_right <= w_dir_right_nxt;
            r_result    <= w_result_nxt;
            r_zero      <= w_zero_nxt;
            r_illegal   <= w_illegal_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit: directed plus random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  alucon    = 4'b0;
    logic [31:0] op_a      = '0;
    logic [31:0] op_b      = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alucon    (alucon),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rnd_or  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the arithmetic meaning of each code.
    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd5 || c == 4'd6) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Drive one op from the posedge+1 phase; returns at posedge+1 after accept.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int stalls);
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        alucon   = c;
        op_a     = a;
        op_b     = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (ok) begin
            e.res = model_res(c, a, b);
            e.z   = (e.res == 32'd0);
            e.ill = (c > 4'd6);
            e.due = cyc + model_lat(c, b);
            sb.push_back(e);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready within 200 cycles, required acceptance of code %0d", c);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alucon   = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!out_valid && in_ready && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding results, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on presentation, value on transfer, stability on hold.
    bit          fresh = 1'b1;
    bit          hold_pending = 1'b0;
    logic [31:0] h_res;
    logic        h_z;
    logic        h_i;

    always @(negedge clk) begin
        if (rst) begin
            fresh        = 1'b1;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid",   32'(out_valid), 32'd1);
                check("hold_result",  result, h_res);
                check("hold_zero",    32'(zero), 32'(h_z));
                check("hold_illegal", 32'(illegal), 32'(h_i));
            end
            if (out_valid && !out_ready) check("hold_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && fresh) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result 0x%08h, required no output", result);
                end else begin
                    check("latency", 32'(cyc), 32'(sb[0].due));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result",  result, e.res);
                check("zero",    32'(zero), 32'(e.z));
                check("illegal", 32'(illegal), 32'(e.ill));
            end
            fresh        = !out_valid || out_ready;
            hold_pending = out_valid && !out_ready;
            h_res        = result;
            h_z          = zero;
            h_i          = illegal;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required $finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          busy;
        int          stale;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result, 32'd0);
        check("rst_zero",      32'(zero), 32'd0);
        check("rst_illegal",   32'(illegal), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(ALU_ADD, 32'd5, 32'd7, st);
        issue(ALU_SUB, 32'd9, 32'd9, st);
        check("b2b_stalls", 32'(st), 32'd0);
        issue(ALU_SUB, 32'd0, 32'd1, st);
        check("b2b_stalls2", 32'(st), 32'd0);

        issue(ALU_SLL, 32'd1, 32'd31, st);
        busy = 0;
        repeat (31) begin
            @(negedge clk);
            if (!in_ready) busy++;
        end
        check("sll_busy_cycles", 32'(busy), 32'd31);
        @(negedge clk);
        check("sll_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(ALU_SRL, 32'h8000_0000, 32'h23, st);

        wait_idle();
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd1, st);
        repeat (5) begin
            @(negedge clk);
            check("bp_result",   result, 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        issue(ALU_XOR, 32'hF0, 32'hFF, st);
        issue(ALU_ILL, 32'd3, 32'd4, st);
        issue(ALU_AND, 32'hC, 32'hA, st);
        issue(4'b0111, 32'h1234, 32'h0, st);
        issue(ALU_SLL, 32'hDEAD_BEEF, 32'h40, st);

        wait_idle();
        rnd_or = 1'b1;
        repeat (150) begin
            c = 4'($urandom_range(0, 8));
            if (c == 4'd8) c = 4'($urandom_range(7, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 0) b = b & 32'h7;
            if ($urandom_range(0, 7) == 0) a = b;
            issue(c, a, b, st);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_or = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();

        issue(ALU_SLL, 32'd1, 32'd20, st);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result",    result, 32'd0);
        check("mid_rst_zero",      32'(zero), 32'd0);
        check("mid_rst_illegal",   32'(illegal), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_output", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd2, 32'd3, st);

        wait_idle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that sits directly downstream of the ALU-control decoder.
- Consumes the 4-bit alucon code plus two operands and produces a registered result, a zero flag for branch compare, and an illegal-op flag.
- Logic ops, add and sub complete in one cycle.
- Shifts run on a bit-serial shifter, one bit per cycle, so the unit uses valid/ready handshakes on both input and output.

Parameters:
- XLEN, 32, datapath width
- SHAMT_W, 5, shift-amount width; equals log2(XLEN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation this cycle
- alucon  in  4  operation code from the ALU-control decoder
- op_a  in  XLEN  first operand
- op_b  in  XLEN  second operand; op_b[SHAMT_W-1:0] is the shift amount
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes the result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- illegal  out  1  registered; the accepted alucon was undefined

Behaviour:
- Codes:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 XOR
  - 0011 OR
  - 0100 AND
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: a >> b[4:0], logical
  - Any other code (incl. 1111) is ILLEGAL.
- Arithmetic: modulo 2^XLEN, carry/borrow discarded, no overflow flag.
- Reset (async, immediate): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0, working register=0. An op in flight is dropped with no output.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). An op is accepted when in_valid && in_ready.
- States: IDLE, SHIFT.
- IDLE, accepted non-shift op, SLL/SRL with shamt==0, or ILLEGAL:
  - Next edge loads result and zero, sets out_valid=1, stays IDLE. Latency is 1 cycle.
  - ILLEGAL loads result=0, zero=1, illegal=1. All other ops load illegal=0.
- IDLE, accepted SLL/SRL with shamt N>0:
  - Next edge loads working=op_a, cnt=N, direction, and moves to SHIFT. out_valid is 0 here, because the accept rule guaranteed any previous result drained.
- SHIFT:
  - Each cycle, working shifts by 1 in the latched direction, zero-filled, and cnt decrements.
  - On the cycle cnt==1, the shifted value loads into result/zero, out_valid=1, and the state goes to IDLE.
  - Total latency from accept to out_valid is N+1 edges; in_ready=0 throughout SHIFT.
- Output hold: while out_valid && !out_ready, result, zero and illegal are stable and in_ready=0.
- Drain: out_valid && out_ready with no new completion on the same edge gives out_valid=0 next cycle. result keeps its last value.
- Simultaneous drain and new single-cycle accept: out_valid stays 1 and result takes the new value (back-to-back throughput of 1 op/cycle).
- op_a, op_b and alucon are sampled only at accept. Changes during SHIFT have no effect.
- in_valid while in_ready=0 is ignored. The producer must hold it (standard valid/ready; no combinational path from in_valid to in_ready).

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_ILL (4'b1111); these same constants are used by the ALU-control decoder.
  - State encoding IDLE/SHIFT.
- Sub-module alu_core: purely combinational ADD/SUB/XOR/OR/AND plus an illegal-detect output.
- alu_exec_unit owns the handshake, FSM, shift counter, working register and output registers.

Test Plan:
- ADD a=5, b=7, out_ready=1 -> one cycle after accept: out_valid=1, result=12, zero=0, illegal=0. Follow with SUB 9-9 on the next cycle -> result=0, zero=1, with in_ready continuously 1.
- SUB a=0, b=1 -> result=0xFFFFFFFF (wrap), zero=0.
- SLL a=1, b=31 -> in_ready=0 for 31 cycles; out_valid at accept+32 with result=0x80000000. SRL a=0x80000000, b=0x23 (shamt 3) -> result=0x10000000 at accept+4.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> result=2 held, in_ready=0; raise out_ready -> in_ready=1 the same cycle, and an XOR 0xF0^0xFF accepted then yields 0x0F next cycle.
- alucon=1111, a=3, b=4 -> result=0, zero=1, illegal=1. Then AND 0xC & 0xA -> result=0x8, illegal=0.
- Assert rst mid-SHIFT (SLL 1<<20, at cycle 10) -> outputs and state reset immediately, no stale result ever appears. After release, ADD 2+3 -> result=5 after 1 cycle.
